// File: rtl/softmax_seq.sv
// softmax_seq -- sequential fixed-point softmax for the classifier tail.
//
// Accepts a frame of N_CLASS signed Q(DW-FRAC).FRAC logits and tracks the
// running maximum. It then computes exp(x - max) one element per cycle using
// a 32-entry base-2 mantissa LUT and a right shift, and accumulates the sum.
// Each element is normalised with one shared restoring divider
// (1 load cycle + OW iteration cycles per element). Finally the frame is
// streamed out as unsigned Q0.OW probabilities, with backpressure.
//
// The frame buffer is reused in place: it holds the logits, then the
// exponentials, then the probabilities.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   in_valid     logit beat valid
//   in_data      signed logit (DW bits)
//   in_ready     registered; high only while loading a frame
//   out_valid    probability beat valid (OUT state)
//   out_data     probability of class out_idx, unsigned Q0.OW
//   out_idx      class index of the current beat
//   out_last     high on beat N_CLASS-1
//   out_ready    downstream accepts beat
//   busy         high unless idle in LOAD with no beat stored yet
//
// Optional feature, enabled with macro SOFTMAX_ARGMAX_EN:
//   argmax_idx   index of the largest logit (lowest index on ties),
//                captured on entry to OUT and held until the next OUT
//   argmax_valid high for the whole OUT state
module softmax_seq #(
  parameter int N_CLASS = 10,
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int OW      = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [OW-1:0]              out_data,
  output logic [$clog2(N_CLASS)-1:0] out_idx,
  output logic                       out_last,
  input  logic                       out_ready,
`ifdef SOFTMAX_ARGMAX_EN
  output logic [$clog2(N_CLASS)-1:0] argmax_idx,
  output logic                       argmax_valid,
`endif
  output logic                       busy
);

  localparam int CW  = $clog2(N_CLASS);
  localparam int SW  = OW + $clog2(N_CLASS);
  localparam int BW  = (DW > OW) ? DW : OW;
  localparam int SCW = $clog2(OW + 1);
  localparam int TW  = DW + 2;

  localparam logic [CW-1:0]  LAST_IDX = CW'(N_CLASS - 1);
  localparam logic [DW-1:0]  MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [SCW-1:0] LAST_STEP = SCW'(OW);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // LUT[f] = round((2^OW - 1) * 2^(-f/32)); evaluated at elaboration only.
  function automatic logic [OW-1:0] lut_entry(input int f);
    real v;
    v = ((2.0 ** OW) - 1.0) * (2.0 ** (-f / 32.0));
    return OW'($rtoi(v + 0.5));
  endfunction

  // A quotient of exactly 2^OW (element equals the whole sum) does not fit
  // in OW bits and is clamped to full scale.
  function automatic logic [OW-1:0] sat_prob(input logic ovf, input logic [OW-1:0] q);
    return ovf ? {OW{1'b1}} : q;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SCW-1:0]        step_q, step_d;
  logic signed [DW-1:0]  max_q, max_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [SW-1:0]         rem_q, rem_d;
  logic [OW-1:0]         quo_q, quo_d;
  logic                  sat_q, sat_d;
  logic                  in_ready_q, in_ready_d;
  logic [BW-1:0]         buf_q [N_CLASS];
  logic [BW-1:0]         buf_d [N_CLASS];
`ifdef SOFTMAX_ARGMAX_EN
  logic [CW-1:0]         max_idx_q, max_idx_d;
  logic [CW-1:0]         argmax_idx_q, argmax_idx_d;
`endif

  logic [OW-1:0] lut [32];
  for (genvar g = 0; g < 32; g++) begin : g_lut
    localparam logic [OW-1:0] LUT_VAL = lut_entry(g);
    assign lut[g] = LUT_VAL;
  end

  logic signed [DW-1:0] in_s;
  logic                 accept;
  logic                 at_last;
  assign in_s    = in_data;
  assign accept  = in_valid && in_ready_q && (state_q == S_LOAD);
  assign at_last = (cnt_q == LAST_IDX);

  // Exponential datapath: e = 2^(-(max - x) * log2(e)), mantissa from LUT.
  logic signed [DW-1:0] x_s;
  logic [DW:0]          d_w;
  logic [DW+9:0]        prod_w;
  logic [TW-1:0]        t_w;
  logic [TW-1:0]        k_w;
  logic [4:0]           f_w;
  logic [OW-1:0]        e_val;
  assign x_s    = buf_q[cnt_q][DW-1:0];
  assign d_w    = {max_q[DW-1], max_q} - {x_s[DW-1], x_s};
  assign prod_w = {9'd0, d_w} * (DW+10)'(369);
  assign t_w    = TW'(prod_w >> 8);
  assign k_w    = t_w >> FRAC;
  assign f_w    = 5'(t_w >> (FRAC - 5));
  assign e_val  = (k_w >= TW'(OW)) ? '0 : (lut[f_w] >> k_w);

  // Divider datapath: one restoring step per cycle on the held remainder.
  logic [OW-1:0] e_cur;
  logic [SW-1:0] e_w;
  logic [SW:0]   shifted;
  logic          qbit;
  logic [OW-1:0] q_next;
  logic          unused_quo_msb;
  assign e_cur          = buf_q[cnt_q][OW-1:0];
  assign e_w            = SW'(e_cur);
  assign shifted        = {rem_q, 1'b0};
  assign qbit           = (shifted >= {1'b0, sum_q});
  assign q_next         = {quo_q[OW-2:0], qbit};
  assign unused_quo_msb = quo_q[OW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    max_d   = max_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sat_d   = sat_q;
    buf_d   = buf_q;
`ifdef SOFTMAX_ARGMAX_EN
    max_idx_d    = max_idx_q;
    argmax_idx_d = argmax_idx_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          buf_d[cnt_q] = BW'(in_data);
          // Strict compare keeps the lowest index on ties.
          if (in_s > max_q) begin
            max_d = in_s;
`ifdef SOFTMAX_ARGMAX_EN
            max_idx_d = cnt_q;
`endif
          end
          if (at_last) begin
            state_d = S_EXP;
            cnt_d   = '0;
            sum_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_EXP: begin
        buf_d[cnt_q] = BW'(e_val);
        sum_d        = sum_q + SW'(e_val);
        if (at_last) begin
          state_d = S_DIV;
          cnt_d   = '0;
          step_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (step_q == '0) begin
          // Load: e <= sum always, so the integer part is 0 or 1.
          quo_d  = '0;
          step_d = SCW'(1);
          if (e_w >= sum_q) begin
            sat_d = 1'b1;
            rem_d = e_w - sum_q;
          end else begin
            sat_d = 1'b0;
            rem_d = e_w;
          end
        end else begin
          rem_d = qbit ? SW'(shifted - {1'b0, sum_q}) : SW'(shifted);
          if (step_q == LAST_STEP) begin
            buf_d[cnt_q] = BW'(sat_prob(sat_q, q_next));
            step_d       = '0;
            if (at_last) begin
              state_d = S_OUT;
              cnt_d   = '0;
`ifdef SOFTMAX_ARGMAX_EN
              argmax_idx_d = max_idx_q;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            quo_d  = q_next;
            step_d = step_q + SCW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            max_d   = MOST_NEG;
            sum_d   = '0;
`ifdef SOFTMAX_ARGMAX_EN
            max_idx_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      step_q     <= '0;
      max_q      <= MOST_NEG;
      sum_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b0;
      buf_q      <= '{default: '0};
`ifdef SOFTMAX_ARGMAX_EN
      max_idx_q    <= '0;
      argmax_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sat_q      <= sat_d;
      in_ready_q <= in_ready_d;
      buf_q      <= buf_d;
`ifdef SOFTMAX_ARGMAX_EN
      max_idx_q    <= max_idx_d;
      argmax_idx_q <= argmax_idx_d;
`endif
    end
  end

  // Output stage: beats are read straight from the buffer at the output index.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? buf_q[cnt_q][OW-1:0] : '0;
  assign out_idx   = out_valid ? cnt_q : '0;
  assign out_last  = out_valid && at_last;
  assign busy      = !((state_q == S_LOAD) && (cnt_q == '0));
`ifdef SOFTMAX_ARGMAX_EN
  assign argmax_idx   = argmax_idx_q;
  assign argmax_valid = (state_q == S_OUT);
`endif

endmodule

// File: tb/tb_softmax_seq.sv
module tb_softmax_seq;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [3:0]    out_idx;
  logic          out_last;
  logic          busy;
`ifdef SOFTMAX_ARGMAX_EN
  logic [3:0]    argmax_idx;
  logic          argmax_valid;
`endif

  softmax_seq #(.N_CLASS(N), .DW(DW), .FRAC(8), .OW(OW)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_last(out_last),
    .out_ready(out_ready),
`ifdef SOFTMAX_ARGMAX_EN
    .argmax_idx(argmax_idx),
    .argmax_valid(argmax_valid),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [9:0][15:0] lg;
    logic [9:0][15:0] pr;
    logic [3:0]       am;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Drives one frame back to back; t0 is the edge count of the first transfer.
  task automatic send_frame(input logic [9:0][15:0] lg, output int t0);
    int g;
    t0 = 0;
    for (int i = 0; i < N; i++) begin
      in_data  = lg[i];
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) begin
        timeout_fail("send in_ready");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i == 0) t0 = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_frame(input logic [9:0][15:0] pr, input logic [3:0] am,
                            input int stall_at, input int stall_len, input string tag);
    int g;
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      g = 0;
      while (!out_valid && g < 400) begin
        @(negedge clk);
        g++;
      end
      if (!out_valid) begin
        timeout_fail($sformatf("%s out_valid beat %0d", tag, j));
        out_ready = 1'b0;
        return;
      end
      chk($sformatf("%s out_idx[%0d]", tag, j), 32'(out_idx), 32'(j));
      chk($sformatf("%s out_data[%0d]", tag, j), 32'(out_data), 32'(pr[j]));
      chk($sformatf("%s out_last[%0d]", tag, j), 32'(out_last), 32'(j == N - 1));
`ifdef SOFTMAX_ARGMAX_EN
      if (j == 0) begin
        chk($sformatf("%s argmax_idx", tag), 32'(argmax_idx), 32'(am));
        chk($sformatf("%s argmax_valid", tag), 32'(argmax_valid), 32'd1);
      end
`endif
      if (j == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk($sformatf("%s stall%0d out_valid", tag, s), 32'(out_valid), 32'd1);
          chk($sformatf("%s stall%0d out_idx", tag, s), 32'(out_idx), 32'(j));
          chk($sformatf("%s stall%0d out_data", tag, s), 32'(out_data), 32'(pr[j]));
          chk($sformatf("%s stall%0d in_ready", tag, s), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk($sformatf("%s end out_valid", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s end in_ready", tag), 32'(in_ready), 32'd1);
    chk($sformatf("%s end busy", tag), 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int t0;
    int g;

    for (int v = 0; v < NV; v++) begin
      vecs[v].lg = '0;
      vecs[v].pr = '0;
      vecs[v].am = '0;
    end
    // all zero: e=65535 each, sum=655350, p=6553
    for (int i = 0; i < N; i++) vecs[0].pr[i] = 16'd6553;
    // single dominant logit at 0 saturates
    vecs[1].lg[0] = 16'h2000;
    vecs[1].pr[0] = 16'd65535;
    // tie at 3 and 7, everything else most negative
    vecs[2].lg = {10{16'h8000}};
    vecs[2].lg[3] = 16'h0100;
    vecs[2].lg[7] = 16'h0100;
    vecs[2].pr[3] = 16'd32768;
    vecs[2].pr[7] = 16'd32768;
    vecs[2].am = 4'd3;
    // dominant logit on the last index
    vecs[3].lg[9] = 16'h2000;
    vecs[3].pr[9] = 16'd65535;
    vecs[3].am = 4'd9;
    // d=178 -> t=256, k=1, f=0 -> e=32767; sum=98302
    vecs[4].lg = {10{16'h8000}};
    vecs[4].lg[0] = 16'h00B2;
    vecs[4].lg[1] = 16'h0000;
    vecs[4].pr[0] = 16'd43690;
    vecs[4].pr[1] = 16'd21845;
    // d=178 -> e=32767, d=356 -> t=513, k=2, f=0 -> e=16383; sum=114685
    vecs[5].lg = {10{16'h8000}};
    vecs[5].lg[0] = 16'h0164;
    vecs[5].lg[1] = 16'h00B2;
    vecs[5].lg[2] = 16'h0000;
    vecs[5].pr[0] = 16'd37449;
    vecs[5].pr[1] = 16'd18724;
    vecs[5].pr[2] = 16'd9361;
    // all equal negative values behave like all zero
    vecs[6].lg = {10{16'hF000}};
    for (int i = 0; i < N; i++) vecs[6].pr[i] = 16'd6553;
    // two maxima at the extreme ends of the range
    vecs[7].lg = {10{16'h8000}};
    vecs[7].lg[0] = 16'h7FFF;
    vecs[7].lg[1] = 16'h7FFF;
    vecs[7].pr[0] = 16'd32768;
    vecs[7].pr[1] = 16'd32768;

    // Reset state
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_idx", 32'(out_idx), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
`ifdef SOFTMAX_ARGMAX_EN
    chk("rst argmax_idx", 32'(argmax_idx), 32'd0);
    chk("rst argmax_valid", 32'(argmax_valid), 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("release in_ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("release in_ready high", 32'(in_ready), 32'd1);

    // Latency and ignored in_valid during EXP
    send_frame(vecs[0].lg, t0);
    in_data  = 16'h7FFF;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("exp in_ready[%0d]", k), 32'(in_ready), 32'd0);
      chk($sformatf("exp busy[%0d]", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) timeout_fail("latency out_valid");
    // The cycle being observed ends at edge cyc+1.
    else chk("latency", 32'(cyc + 1 - t0), 32'd190);
    recv_frame(vecs[0].pr, vecs[0].am, -1, 0, "lat");

    // Table of frames
    for (int v = 1; v < NV; v++) begin
      send_frame(vecs[v].lg, t0);
      recv_frame(vecs[v].pr, vecs[v].am, -1, 0, $sformatf("vec%0d", v));
    end

    // Backpressure at beat 2 for 5 cycles
    send_frame(vecs[5].lg, t0);
    recv_frame(vecs[5].pr, vecs[5].am, 2, 5, "bp");

    // Reset during DIV
    send_frame(vecs[2].lg, t0);
    repeat (40) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid out_valid", 32'(out_valid), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mid release in_ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mid release in_ready high", 32'(in_ready), 32'd1);
    chk("mid release out_valid", 32'(out_valid), 32'd0);
    send_frame(vecs[0].lg, t0);
    recv_frame(vecs[0].pr, vecs[0].am, -1, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_seq.md
Name: softmax_seq

Overview:
- Parametrised, synthesizable fixed-point softmax for the classifier tail; successor to the fixed 10-input, real-valued softmax stage.
- Takes N_CLASS signed logits as a valid/ready stream and subtracts the maximum for range safety.
- Computes exp with a base-2 LUT and normalises with one shared sequential divider.
- Streams N_CLASS unsigned probabilities out with backpressure.

Parameters:
- N_CLASS, 10, number of logits per frame (2..256).
- DW, 16, input logit width, signed two's complement.
- FRAC, 8, fractional bits of input logit (Q(DW-FRAC).FRAC); must be >=5.
- OW, 16, output probability width, unsigned Q0.OW.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  logit beat valid.
- in_data  in  DW  signed logit.
- in_ready  out  1  block accepts a logit this cycle.
- out_valid  out  1  probability beat valid.
- out_data  out  OW  probability of class out_idx.
- out_idx  out  clog2(N_CLASS)  class index of current beat.
- out_last  out  1  high on beat N_CLASS-1.
- out_ready  in  1  downstream accepts beat.
- busy  out  1  high in any state other than LOAD with count 0.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on resetn. While resetn is low:
  - state=LOAD, all counters 0, buffers 0, max register = most negative value.
  - in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - in_ready is registered and rises on the first clk edge after resetn is released.
  - Reset mid-frame discards the frame; no partial output.
- Beat transfer rule: a beat transfers when valid & ready. in_ready is high only in LOAD.
- LOAD:
  - Each accepted beat stores the logit at buf[cnt] and increments cnt.
  - Max tracking: max updates only if in_data > max, so the lowest index wins ties. Argmax index is tracked alongside.
  - After beat N_CLASS-1: go to EXP, cnt=0. in_ready drops the same edge.
- EXP (one element per cycle, N_CLASS cycles):
  - d = max - buf[i], unsigned, width DW+1.
  - t = (d*369)>>8, where 369 is log2(e) in Q8.
  - k = t>>FRAC.
  - f = t[FRAC-1:FRAC-5].
  - e = (k>=OW) ? 0 : LUT[f]>>k, with LUT[f] = round((2^OW-1)*2^(-f/32)), 32 entries.
  - The max element always yields e = 2^OW-1.
  - buf[i] is overwritten with e; sum accumulates in width OW+clog2(N_CLASS) and cannot overflow.
- DIV:
  - Restoring divider; per element: 1 load cycle + OW iteration cycles.
  - p = floor(e*2^OW / sum), saturated to 2^OW-1 when the quotient equals 2^OW.
  - Result is written back to buf[i]. After N_CLASS elements go to OUT.
- OUT:
  - out_valid=1; out_data=buf[j], out_idx=j, out_last=(j==N_CLASS-1).
  - While out_ready=0, all outputs hold stable.
  - Transfer of the last beat goes to LOAD; in_ready=1 on the next cycle.
  - Input is never accepted while output is pending; there is no overlap between frames.
- Latency, first accepted beat to first out_valid: N_CLASS + N_CLASS + N_CLASS*(OW+1) cycles; fixed, data-independent.
- in_valid outside LOAD is ignored. out_ready outside OUT is ignored.

Optional Feature:
- Macro SOFTMAX_ARGMAX_EN.
- Defined:
  - Adds output ports argmax_idx (clog2(N_CLASS)) and argmax_valid (1).
  - argmax_idx takes the LOAD-tracked index (lowest index on ties) on entry to OUT and holds it until the next frame's OUT.
  - argmax_valid is high for the whole OUT state.
  - Both reset to 0.
- Undefined: ports and tracking logic are absent; everything else is identical.

Test Plan:
- Ten logits all 0x0000 -> every e=65535, sum=655350, every out_data=6553; out_idx 0..9; out_last only on idx 9.
- Logit0=0x2000 (32.0), others 0x0000 -> out_data[0]=65535 (saturated), others 0; argmax_idx=0.
- Idx3=idx7=0x0100, others 0x8000 -> p3=p7=32768, all others 0; argmax_idx=3 (tie, lowest index).
- Backpressure: hold out_ready=0 for 5 cycles at beat 2 -> out_data/out_idx stable; all 10 beats delivered exactly once; in_ready stays 0 until after the last beat.
- Reset asserted mid-DIV -> out_valid=0 and in_ready=0 immediately; in_ready=1 one cycle after release; the next frame of all-zero logits yields 6553 on every beat.
- Latency check: N_CLASS=10, OW=16 -> first out_valid exactly 190 cycles after the first accepted beat; in_valid pulsed during EXP is not consumed.
